ddr_burst_arb: RTL
==================

Name: ddr_burst_arb

Overview:
- Schedules DDR3 UI burst access among independent requesters: mask read, image write and image read.
- Sits in front of the single burst engine that drives app_en/app_cmd/app_addr and the write-data path.
- Grants one burst at a time using fixed priority with starvation aging.
- Hands the engine the winning address and direction, then waits for burst completion before re-arbitrating.

Parameters:
- N_REQ, 3, number of requesters; index 0 is highest static priority.
- ADDR_W, 30, UI address width.
- MAX_WAIT, 8, number of lost arbitrations after which a waiting requester is promoted.
- TIMEOUT, 1024, cycles allowed from eng_start to eng_done before abort.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- calib_done  in  1  DDR calibration complete; no grants are issued while low.
- req  in  N_REQ  per-requester burst request level, held until granted.
- req_wr  in  N_REQ  per-requester direction: 1 = write, 0 = read.
- req_addr  in  N_REQ*ADDR_W  per-requester burst start address; requester i occupies slice i.
- gnt  out  N_REQ  one-hot, one-cycle grant pulse.
- eng_start  out  1  one-cycle burst start pulse to the engine.
- eng_wr  out  1  latched direction of the active burst.
- eng_addr  out  ADDR_W  latched start address of the active burst.
- eng_done  in  1  one-cycle pulse from the engine when the burst has completed.
- active_id  out  2  index of the active or last granted requester.
- busy  out  1  high from grant until done or abort.
- err_timeout  out  1  sticky flag; cleared only by reset.
- stat_sel  in  2  statistics select (used only with the optional feature).
- stat_data  out  32  selected statistics counter.

Behaviour:
- Reset values: all outputs 0. State is IDLE and all wait counters are 0.
- States are IDLE, ISSUE and WAIT_DONE.
- IDLE:
  - Arbitration runs when calib_done=1 and req!=0.
  - Winner selection: the lowest-index starved requester (wait_cnt==MAX_WAIT) wins. If none is starved, the lowest-index requester wins.
  - At the winner's edge, latch eng_addr/eng_wr/active_id and move to ISSUE.
- ISSUE:
  - gnt[winner] and eng_start pulse together for exactly 1 cycle.
  - busy is set. Next state is WAIT_DONE.
  - Latency: req sampled at edge t gives gnt/eng_start high during cycle t+1.
- WAIT_DONE:
  - eng_done=1 sends the block to IDLE and clears busy on the same edge.
  - A new grant is possible at the earliest 2 cycles after done.
  - eng_done is ignored in any state other than WAIT_DONE.
- Aging:
  - On each grant, every other requester with req=1 increments its wait_cnt.
  - wait_cnt saturates at MAX_WAIT.
  - The winner's wait_cnt is cleared.
  - Any requester with req=0 has wait_cnt cleared every cycle.
- Timeout:
  - A counter starts at eng_start.
  - If it reaches TIMEOUT-1 without eng_done: set err_timeout, clear busy, go to IDLE.
  - Arbitration continues normally after a timeout.
- Requester deasserting req before its grant edge is not granted; no error.
- Simultaneous requests plus done: done is processed first; arbitration occurs in the following IDLE cycle.
- calib_done falling mid-burst: the current burst completes normally. No further grants are issued until calib_done returns high.
- Asynchronous reset mid-burst: immediate return to IDLE with all outputs 0. The burst engine is reset by the same signal.
- Address and direction are taken only from the winner's slice at the winner's edge. Later changes to the slice do not affect the active burst.

Optional Feature:
- Macro: DDR_BURST_ARB_STATS_EN.
- When defined:
  - Per-requester 32-bit grant counters wrap at 2^32 and reset to 0.
  - stat_data = counter[stat_sel] for stat_sel < N_REQ.
  - stat_sel == 3 selects the timeout event count.
  - stat_data is registered, with 1-cycle latency.
- When undefined: stat_data is tied to 0 and no counters are synthesised.

Decomposition:
- Shared package ddr_arb_pkg holds:
  - the state enum (IDLE/ISSUE/WAIT_DONE);
  - ADDR_W default;
  - requester ID constants REQ_MASK_RD=0, REQ_IMG_WR=1, REQ_IMG_RD=2;
  - the UI command codes CMD_WR=3'b000, CMD_RD=3'b001.
- One natural sub-module: ddr_arb_pick.
  - Purely combinational.
  - Takes req and the starved vector; outputs one-hot winner plus index.
  - Instantiated once.

Test Plan:
- Reset, then req=3'b111 with calib_done=1 → gnt=3'b001 during cycle t+1, and eng_addr = slice 0. After eng_done, the next grant is 3'b001 again until aging triggers.
- req[0] held continuously with req[2] held → req[2] is granted on the 9th grant (MAX_WAIT=8), and wait_cnt[2] returns to 0.
- calib_done=0 with req=3'b010 for 100 cycles → no gnt and busy=0. Raising calib_done → gnt=3'b010 two cycles later.
- Grant given, eng_done withheld → err_timeout=1 and busy=0 at start+1024 cycles; the next request is granted normally.
- Assert reset during WAIT_DONE → all outputs 0 immediately, and a fresh request is granted with ISSUE latency 1.
- With DDR_BURST_ARB_STATS_EN: 5 grants to req 1 and stat_sel=1 → stat_data=5 one cycle later.

Source files
------------

// File: rtl/ddr_arb_pkg.sv
// Shared types and constants for the DDR3 UI burst arbiter.
package ddr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_t;

  localparam int ADDR_W_DEF = 30;

  localparam int REQ_MASK_RD = 0;
  localparam int REQ_IMG_WR  = 1;
  localparam int REQ_IMG_RD  = 2;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

endpackage

// File: rtl/ddr_arb_pick.sv
// Combinational winner select: lowest-index starved requester, else lowest-index requester.
module ddr_arb_pick #(
  parameter int N_REQ = 3
) (
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] starved,
  output logic [N_REQ-1:0] win_oh,
  output logic [1:0]       win_idx
);

  logic [N_REQ-1:0] cand;
  logic             found;

  always_comb begin
    cand    = (|(req & starved)) ? (req & starved) : req;
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (cand[i] && !found) begin
        win_oh[i] = 1'b1;
        win_idx   = 2'(i);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr_burst_arb.sv
// Fixed-priority burst arbiter with starvation aging and engine timeout in front of one DDR3 UI burst engine.
// Optional grant/timeout statistics are built when DDR_BURST_ARB_STATS_EN is defined.
module ddr_burst_arb
  import ddr_arb_pkg::*;
#(
  parameter int N_REQ    = 3,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int MAX_WAIT = 8,
  parameter int TIMEOUT  = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    calib_done,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        req_wr,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        gnt,
  output logic                    eng_start,
  output logic                    eng_wr,
  output logic [ADDR_W-1:0]       eng_addr,
  input  logic                    eng_done,
  output logic [1:0]              active_id,
  output logic                    busy,
  output logic                    err_timeout,
  input  logic [1:0]              stat_sel,
  output logic [31:0]             stat_data,
  output logic [1:0]              dbg_state
);

  // Handshake: a requester holds req[i] high until it sees its one-cycle gnt[i];
  // dropping req earlier withdraws the request. The engine owns the burst from
  // eng_start until it returns a single eng_done pulse.
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int TMO_W  = $clog2(TIMEOUT);

  arb_state_t        state;
  logic [WAIT_W-1:0] wait_cnt [N_REQ];
  logic [N_REQ-1:0]  starved;
  logic [N_REQ-1:0]  win_oh;
  logic [1:0]        win_idx;
  logic [ADDR_W-1:0] win_addr;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              grant_now;
  logic              tmo_fire;

  assign dbg_state = state;
  assign grant_now = (state == IDLE) && calib_done && (|req);
  assign tmo_fire  = (state == WAIT_DONE) && !eng_done && (tmo_cnt == TMO_W'(TIMEOUT - 1));

  always_comb begin
    for (int i = 0; i < N_REQ; i++) starved[i] = (wait_cnt[i] == WAIT_W'(MAX_WAIT));
  end

  always_comb begin
    win_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_oh[i]) win_addr = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  ddr_arb_pick #(.N_REQ(N_REQ)) u_pick (
    .req     (req),
    .starved (starved),
    .win_oh  (win_oh),
    .win_idx (win_idx)
  );

  // Losers that are still requesting age by one per grant; idle requesters forget their wait.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_REQ; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!req[i]) begin
          wait_cnt[i] <= '0;
        end else if (grant_now) begin
          if (win_oh[i])                              wait_cnt[i] <= '0;
          else if (wait_cnt[i] != WAIT_W'(MAX_WAIT))  wait_cnt[i] <= wait_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      gnt         <= '0;
      eng_start   <= 1'b0;
      eng_wr      <= 1'b0;
      eng_addr    <= '0;
      active_id   <= '0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      gnt       <= '0;
      eng_start <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_now) begin
            gnt       <= win_oh;
            eng_start <= 1'b1;
            busy      <= 1'b1;
            eng_wr    <= |(req_wr & win_oh);
            eng_addr  <= win_addr;
            active_id <= win_idx;
            tmo_cnt   <= '0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          state   <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (eng_done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (tmo_fire) begin
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DDR_BURST_ARB_STATS_EN
  logic [31:0] gnt_cnt [N_REQ];
  logic [31:0] tmo_evt;
  logic [31:0] stat_next;

  always_comb begin
    stat_next = '0;
    if (stat_sel == 2'd3) begin
      stat_next = tmo_evt;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (stat_sel == 2'(i)) stat_next = gnt_cnt[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_REQ; i++) gnt_cnt[i] <= '0;
      tmo_evt   <= '0;
      stat_data <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (grant_now && win_oh[i]) gnt_cnt[i] <= gnt_cnt[i] + 32'd1;
      end
      if (tmo_fire) tmo_evt <= tmo_evt + 32'd1;
      stat_data <= stat_next;
    end
  end
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_data       = '0;
`endif

endmodule
